psram_bram_responder: RTL and testbench

Synthesizable stand-in for the PSRAM controller that answers the same `read`/`write`/`byte_write`/`addr`/`din` → `dout`/`busy` command interface from on-chip block RAM. It allows the memory test top, and other initiators, to run on-board and in simulation without external PSRAM. It reproduces the controller's post-reset busy period and its 1x/2x latency behaviour, so the initiator's latency counters and timeouts are exercised.

---
 rtl/psram_bram_responder.sv | 186 ++++++++++++++++++
 tb/tb_psram_bram_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_bram_responder.sv
// -----------------------------------------------------------------------------
// psram_bram_responder
//
// Block-RAM stand-in for the PSRAM controller. It answers the controller's
// read/write command interface from on-chip memory. It also reproduces the
// controller's post-reset busy period and its 1x/2x (refresh collision)
// latency, so an initiator's latency counters and timeouts see realistic
// timing.
//
// Parameters
//   LATENCY        base latency in clocks; busy lengths derive from it
//   INIT_CYCLES    clocks busy stays high after reset release
//   MEM_ADDR_BITS  word-address width (2^MEM_ADDR_BITS x 16-bit words)
//   REFRESH_PERIOD length of the free-running refresh counter
//   REFRESH_WINDOW counter values below this give 2x latency (0 = never)
//
// Ports
//   clk         single clock, rising edge
//   resetn      asynchronous active-low reset
//   read        read command strobe
//   write       write command strobe (wins over read when both are high)
//   byte_write  1 = write only the byte lane selected by addr[0]
//   addr [21:0] byte address; word index is addr[MEM_ADDR_BITS:1]
//   din  [15:0] write data
//   dout [15:0] registered read data; holds until the next read completes
//   busy        high during init and while a command is in progress
//   double_lat  1 if the most recently accepted command used 2x latency
// -----------------------------------------------------------------------------
module psram_bram_responder #(
   parameter int LATENCY        = 3,
   parameter int INIT_CYCLES    = 100,
   parameter int MEM_ADDR_BITS  = 12,
   parameter int REFRESH_PERIOD = 64,
   parameter int REFRESH_WINDOW = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        read,
   input  logic        write,
   input  logic        byte_write,
   input  logic [21:0] addr,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        busy,
   output logic        double_lat
);

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_WR_LAT = 2'd2;
   localparam logic [1:0] ST_RD_LAT = 2'd3;

   localparam int DEPTH = 1 << MEM_ADDR_BITS;
   localparam int REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_PERIOD - 1);

   // Countdown loads are "busy length minus one": the countdown reaches zero
   // on the edge before busy falls, and that final edge ends the command.
   localparam logic [15:0] INIT_LOAD = (INIT_CYCLES > 0) ? 16'(INIT_CYCLES - 1) : 16'd0;
   localparam logic [15:0] WR_1X     = 16'(LATENCY + 1);
   localparam logic [15:0] WR_2X     = 16'(2 * LATENCY + 1);
   localparam logic [15:0] RD_1X     = 16'(LATENCY + 5);
   localparam logic [15:0] RD_2X     = 16'(2 * LATENCY + 5);

   logic [1:0]               state;
   logic [15:0]              cnt;
   logic [REF_W-1:0]         refresh_cnt;
   logic [MEM_ADDR_BITS-1:0] cmd_idx;
   logic [15:0]              cmd_data;
   logic                     cmd_byte;
   logic                     cmd_lane;
   logic [15:0]              rd_word;
   logic [15:0]              mem [DEPTH];

   logic accept;
   logic use_2x;
   logic mem_we;
   logic we_lo;
   logic we_hi;

   // Address bits above the word index simply alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[21:MEM_ADDR_BITS+1];

   assign accept = (state == ST_IDLE) && !busy && (read || write);
   assign use_2x = (REFRESH_WINDOW > 0) && (32'(refresh_cnt) < 32'(REFRESH_WINDOW));

   // The memory is written on the last edge of the write countdown, from the
   // captured command, so an aborting reset may leave it untouched.
   assign mem_we = (state == ST_WR_LAT) && (cnt == '0);
   assign we_lo  = mem_we && (!cmd_byte || !cmd_lane);
   assign we_hi  = mem_we && (!cmd_byte ||  cmd_lane);

   // Free-running refresh counter; it only steers the latency choice.
   // NOTE: state registers use non-blocking assignments and an asynchronous
   // reset, so every flop updates from pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         refresh_cnt <= '0;
      end else if (refresh_cnt == REF_LAST) begin
         refresh_cnt <= '0;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_INIT;
         busy       <= 1'b1;
         dout       <= '0;
         double_lat <= 1'b0;
         cnt        <= INIT_LOAD;
         cmd_idx    <= '0;
         cmd_data   <= '0;
         cmd_byte   <= 1'b0;
         cmd_lane   <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  busy       <= 1'b1;
                  double_lat <= use_2x;
                  cmd_idx    <= addr[MEM_ADDR_BITS:1];
                  cmd_data   <= din;
                  cmd_byte   <= byte_write;
                  cmd_lane   <= addr[0];
                  // A simultaneous read strobe is dropped; the write wins.
                  if (write) begin
                     state <= ST_WR_LAT;
                     cnt   <= use_2x ? WR_2X : WR_1X;
                  end else begin
                     state <= ST_RD_LAT;
                     cnt   <= use_2x ? RD_2X : RD_1X;
                  end
               end
            end
            ST_WR_LAT: begin
               if (cnt == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RD_LAT: begin
               // rd_word has been valid since the edge after acceptance, so
               // the RAM pipeline is hidden inside the countdown.
               if (cnt == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  dout  <= rd_word;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= ST_INIT;
               busy  <= 1'b1;
               cnt   <= INIT_LOAD;
            end
         endcase
      end
   end

   // NOTE: the RAM array and its read register have no reset so they map onto
   // block RAM; contents survive resetn.
   always_ff @(posedge clk) begin
      if (we_lo) begin
         mem[cmd_idx][7:0] <= cmd_data[7:0];
      end
      if (we_hi) begin
         mem[cmd_idx][15:8] <= cmd_data[15:8];
      end
      rd_word <= mem[cmd_idx];
   end

endmodule

// File: tb/tb_psram_bram_responder.sv
// -----------------------------------------------------------------------------
// tb_psram_bram_responder
//
// Directed bench for psram_bram_responder. Each issued command pushes its
// expected busy length, double_lat and dout into a scoreboard queue; a monitor
// measures every busy period at the falling clock edge and compares it against
// the head of the queue when busy drops.
// -----------------------------------------------------------------------------
module tb_psram_bram_responder;

   localparam int LATENCY        = 3;
   localparam int INIT_CYCLES    = 20;
   localparam int MEM_ADDR_BITS  = 12;
   localparam int REFRESH_PERIOD = 64;
   localparam int REFRESH_WINDOW = 8;

   logic        clk        = 1'b0;
   logic        resetn     = 1'b0;
   logic        read       = 1'b0;
   logic        write      = 1'b0;
   logic        byte_write = 1'b0;
   logic [21:0] addr       = '0;
   logic [15:0] din        = '0;
   logic [15:0] dout;
   logic        busy;
   logic        double_lat;

   typedef struct packed {
      logic [31:0] id;
      logic [7:0]  len;
      logic        dl;
      logic [15:0] dout;
   } exp_t;

   exp_t        sb[$];
   int          checks    = 0;
   int          errors    = 0;
   int          cmd_id    = 0;
   int          ref_cnt;
   logic [15:0] exp_dout  = 16'h0000;

   psram_bram_responder #(
      .LATENCY        (LATENCY),
      .INIT_CYCLES    (INIT_CYCLES),
      .MEM_ADDR_BITS  (MEM_ADDR_BITS),
      .REFRESH_PERIOD (REFRESH_PERIOD),
      .REFRESH_WINDOW (REFRESH_WINDOW)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .read       (read),
      .write      (write),
      .byte_write (byte_write),
      .addr       (addr),
      .din        (din),
      .dout       (dout),
      .busy       (busy),
      .double_lat (double_lat)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Bench's own view of the refresh count the DUT will sample at the next edge.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) ref_cnt <= 0;
      else         ref_cnt <= (ref_cnt == REFRESH_PERIOD - 1) ? 0 : ref_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: measures each busy period that starts from idle.
   always @(negedge clk) begin : monitor
      int   run_len;
      bit   in_run;
      logic prev_busy;
      exp_t e;
      if (!resetn) begin
         in_run    = 0;
         run_len   = 0;
         prev_busy = 1'b1;
      end else begin
         if (busy === 1'b1) begin
            if (in_run) begin
               run_len++;
            end else if (prev_busy === 1'b0) begin
               in_run  = 1;
               run_len = 1;
            end
         end else if (in_run) begin
            in_run = 0;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected busy period: length %0d, none expected", run_len);
            end else begin
               e = sb.pop_front();
               check($sformatf("cmd%0d busy_len", e.id), 32'(run_len), 32'(e.len));
               check($sformatf("cmd%0d double_lat", e.id), 32'(double_lat), 32'(e.dl));
               check($sformatf("cmd%0d dout", e.id), 32'(dout), 32'(e.dout));
            end
         end
         prev_busy = busy;
      end
   end

   // Waits for idle and the wanted refresh count (want_ref < 0: any 1x slot),
   // then drives one command for one clock.
   task automatic issue(input logic rd, input logic wr, input logic bw,
                        input logic [21:0] a, input logic [15:0] d,
                        input int want_ref, input logic [15:0] rd_exp, input bit push);
      bit   ok = 0;
      logic dl;
      exp_t e;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (busy === 1'b0 &&
             ((want_ref < 0) ? (ref_cnt >= REFRESH_WINDOW) : (ref_cnt == want_ref))) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL cmd%0d issue timeout: DUT never idle at wanted refresh slot", cmd_id);
      end else begin
         dl = (ref_cnt < REFRESH_WINDOW);
         read = rd; write = wr; byte_write = bw; addr = a; din = d;
         if (!wr && push) exp_dout = rd_exp;
         e.id   = 32'(cmd_id);
         e.dl   = dl;
         e.len  = wr ? 8'(dl ? 2*LATENCY + 2 : LATENCY + 2)
                     : 8'(dl ? 2*LATENCY + 6 : LATENCY + 6);
         e.dout = exp_dout;
         if (push) sb.push_back(e);
         @(negedge clk);
         read = 1'b0; write = 1'b0; byte_write = 1'b0;
      end
      cmd_id++;
   endtask

   // Called at the falling edge where resetn was released. Also pulses a
   // write during init, which must be ignored.
   task automatic init_check(input string tag);
      int edges = 0;
      bit fell  = 0;
      for (int i = 1; i <= INIT_CYCLES + 10; i++) begin
         if (i == 5) begin
            write = 1'b1; addr = 22'h40; din = 16'hDEAD;
         end
         @(negedge clk);
         write = 1'b0;
         if (busy === 1'b0) begin
            edges = i;
            fell  = 1;
            break;
         end
      end
      if (!fell) begin
         checks++;
         errors++;
         $display("FAIL %s busy never fell after reset", tag);
      end else begin
         check({tag, " busy edges"}, 32'(edges), 32'(INIT_CYCLES));
      end
      check({tag, " double_lat"}, 32'(double_lat), 32'd0);
      check({tag, " dout"}, 32'(dout), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd1);
      check("reset dout", 32'(dout), 32'd0);
      check("reset double_lat", 32'(double_lat), 32'd0);
      resetn = 1'b1;
      init_check("init");

      // Word write/read at 1x
      issue(0, 1, 0, 22'h10,   16'h1234, -1, 16'h0000, 1);
      issue(1, 0, 0, 22'h10,   16'h0000, -1, 16'h1234, 1);
      // Byte lanes and aliasing
      issue(0, 1, 1, 22'h11,   16'hABAB, -1, 16'h0000, 1);
      issue(1, 0, 0, 22'h10,   16'h0000, -1, 16'hAB34, 1);
      issue(0, 1, 1, 22'h10,   16'h5656, -1, 16'h0000, 1);
      issue(1, 0, 0, 22'h10,   16'h0000, -1, 16'hAB56, 1);
      issue(1, 0, 0, 22'h2010, 16'h0000, -1, 16'hAB56, 1);
      // 2x latency inside the refresh window, 1x outside it
      issue(0, 1, 0, 22'h50,   16'h0F0F,  3, 16'h0000, 1);
      issue(1, 0, 0, 22'h10,   16'h0000,  5, 16'hAB56, 1);
      issue(1, 0, 0, 22'h50,   16'h0000, 40, 16'h0F0F, 1);
      // read and write together: write only, dout unchanged
      issue(1, 1, 0, 22'h20,   16'hBEEF, -1, 16'h0000, 1);
      issue(1, 0, 0, 22'h20,   16'h0000, -1, 16'hBEEF, 1);
      // read strobe during a busy write is ignored
      issue(0, 1, 0, 22'h30,   16'hCAFE, -1, 16'h0000, 1);
      @(negedge clk);
      read = 1'b1; addr = 22'h10;
      @(negedge clk);
      read = 1'b0;
      drain();

      // Reset in the middle of a read of 16'hCAFE
      issue(1, 0, 0, 22'h30, 16'h0000, -1, 16'h0000, 0);
      repeat (3) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      check("midread reset busy", 32'(busy), 32'd1);
      check("midread reset dout", 32'(dout), 32'd0);
      exp_dout = 16'h0000;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      init_check("reinit");
      issue(1, 0, 0, 22'h30, 16'h0000, -1, 16'hCAFE, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
